// File: rtl/spatz_vrf_wport_arbiter_pkg.sv
// +--------------------------------------------------------------------------+
// | spatz_vrf_wport_arbiter_pkg : VRF write-port types shared by the arbiter  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

package spatz_vrf_wport_arbiter_pkg;

  localparam int unsigned VRF_ADDR_W = 10;
  localparam int unsigned VRF_DATA_W = 64;
  localparam int unsigned VRF_BE_W   = VRF_DATA_W / 8;

  typedef logic [VRF_ADDR_W-1:0] vreg_addr_t;
  typedef logic [VRF_DATA_W-1:0] vreg_data_t;
  typedef logic [VRF_BE_W-1:0]   vreg_be_t;

  typedef struct packed {
    vreg_addr_t addr;
    vreg_data_t data;
    vreg_be_t   be;
  } vrf_wreq_t;

  // Callers only pass idx < 2*n, so one conditional subtract is a full modulo.
  function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
    return (idx >= n) ? (idx - n) : idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spatz_vrf_wport_arbiter_if.sv
// +--------------------------------------------------------------------------+
// | spatz_vrf_wport_arbiter_if : unit request side and VRF write-port side    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

interface spatz_vrf_wport_arbiter_if #(
  parameter int unsigned NR_REQ   = 3,
  parameter int unsigned NR_PORTS = 2
) ();
  import spatz_vrf_wport_arbiter_pkg::*;

  logic       [NR_REQ-1:0]   req_valid_i;
  logic       [NR_REQ-1:0]   req_ready_o;
  vreg_addr_t [NR_REQ-1:0]   req_waddr_i;
  vreg_data_t [NR_REQ-1:0]   req_wdata_i;
  vreg_be_t   [NR_REQ-1:0]   req_wbe_i;
  logic       [NR_REQ-1:0]   req_wack_o;

  vreg_addr_t [NR_PORTS-1:0] vrf_waddr_o;
  vreg_data_t [NR_PORTS-1:0] vrf_wdata_o;
  vreg_be_t   [NR_PORTS-1:0] vrf_wbe_o;
  logic       [NR_PORTS-1:0] vrf_we_o;
  logic       [NR_PORTS-1:0] vrf_wvalid_i;

  modport slave (
    input  req_valid_i, req_waddr_i, req_wdata_i, req_wbe_i, vrf_wvalid_i,
    output req_ready_o, req_wack_o, vrf_waddr_o, vrf_wdata_o, vrf_wbe_o, vrf_we_o
  );

  modport master (
    output req_valid_i, req_waddr_i, req_wdata_i, req_wbe_i, vrf_wvalid_i,
    input  req_ready_o, req_wack_o, vrf_waddr_o, vrf_wdata_o, vrf_wbe_o, vrf_we_o
  );

endinterface

`default_nettype wire

// File: rtl/spatz_vrf_wport_arbiter_alloc.sv
// +--------------------------------------------------------------------------+
// | spatz_rr_alloc : round-robin N-to-M allocator of requesters onto ports    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module spatz_rr_alloc
  import spatz_vrf_wport_arbiter_pkg::*;
#(
  parameter int unsigned NR_REQ   = 3,
  parameter int unsigned NR_PORTS = 2,
  parameter int unsigned IDX_W    = $clog2(NR_REQ)
) (
  input  logic [NR_REQ-1:0]               eligible_i,
  input  logic [NR_PORTS-1:0]             free_i,
  input  logic [IDX_W-1:0]                rr_ptr_i,
  output logic [NR_REQ-1:0]               req_grant_o,
  output logic [NR_PORTS-1:0]             port_grant_o,
  output logic [NR_PORTS-1:0][IDX_W-1:0]  port_owner_o,
  output logic                            any_grant_o,
  output logic [IDX_W-1:0]                next_ptr_o
);

  always_comb begin
    int unsigned r;
    logic        placed;
    r            = 0;
    placed       = 1'b0;
    req_grant_o  = '0;
    port_grant_o = '0;
    port_owner_o = '0;
    any_grant_o  = 1'b0;
    next_ptr_o   = rr_ptr_i;
    // Requesters in priority order; each takes the lowest port still untaken.
    for (int unsigned k = 0; k < NR_REQ; k++) begin
      r      = rr_wrap(int'(rr_ptr_i) + k, NR_REQ);
      placed = 1'b0;
      if (eligible_i[r]) begin
        for (int unsigned p = 0; p < NR_PORTS; p++) begin
          if (!placed && free_i[p] && !port_grant_o[p]) begin
            placed          = 1'b1;
            port_grant_o[p] = 1'b1;
            port_owner_o[p] = IDX_W'(r);
            req_grant_o[r]  = 1'b1;
            any_grant_o     = 1'b1;
            next_ptr_o      = IDX_W'(rr_wrap(r + 1, NR_REQ));
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/spatz_vrf_wport_arbiter.sv
// +--------------------------------------------------------------------------+
// | spatz_vrf_wport_arbiter : shares NR_PORTS VRF write ports among NR_REQ   |
// | units with round-robin grants, held port registers and commit acks.      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module spatz_vrf_wport_arbiter
  import spatz_vrf_wport_arbiter_pkg::*;
#(
  parameter int unsigned NR_REQ   = 3,
  parameter int unsigned NR_PORTS = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  spatz_vrf_wport_arbiter_if.slave   wport_io
);

  localparam int unsigned IDX_W = $clog2(NR_REQ);

  if (NR_REQ < 2) begin : g_chk_nr_req
    $error("spatz_vrf_wport_arbiter: NR_REQ must be at least 2");
  end
  if ((NR_PORTS < 1) || (NR_PORTS > NR_REQ)) begin : g_chk_nr_ports
    $error("spatz_vrf_wport_arbiter: NR_PORTS must be in 1..NR_REQ");
  end

  logic      [NR_PORTS-1:0]            busy_q, busy_d;
  vrf_wreq_t [NR_PORTS-1:0]            port_q, port_d;
  logic      [NR_PORTS-1:0][IDX_W-1:0] owner_q, owner_d;
  logic      [NR_REQ-1:0]              outstanding_q, outstanding_d;
  logic      [IDX_W-1:0]               rr_ptr_q, rr_ptr_d;

  logic      [NR_PORTS-1:0]            retire, port_free, port_grant;
  logic      [NR_PORTS-1:0][IDX_W-1:0] alloc_owner;
  logic      [NR_REQ-1:0]              wack, eligible, req_grant;
  logic                                any_grant;
  logic      [IDX_W-1:0]               next_ptr;

  // A write acknowledged by the VRF frees its port for reuse in the same cycle.
  assign retire    = busy_q & wport_io.vrf_wvalid_i;
  assign port_free = ~busy_q | retire;

  always_comb begin
    wack = '0;
    for (int unsigned r = 0; r < NR_REQ; r++) begin
      for (int unsigned p = 0; p < NR_PORTS; p++) begin
        if (retire[p] && (owner_q[p] == IDX_W'(r))) begin
          wack[r] = 1'b1;
        end
      end
    end
  end

  // One write in flight per unit keeps each unit's writes in order.
  assign eligible = wport_io.req_valid_i & (~outstanding_q | wack);

  spatz_rr_alloc #(
    .NR_REQ   (NR_REQ),
    .NR_PORTS (NR_PORTS),
    .IDX_W    (IDX_W)
  ) i_alloc (
    .eligible_i   (eligible),
    .free_i       (port_free),
    .rr_ptr_i     (rr_ptr_q),
    .req_grant_o  (req_grant),
    .port_grant_o (port_grant),
    .port_owner_o (alloc_owner),
    .any_grant_o  (any_grant),
    .next_ptr_o   (next_ptr)
  );

  always_comb begin
    busy_d  = busy_q;
    port_d  = port_q;
    owner_d = owner_q;
    for (int unsigned p = 0; p < NR_PORTS; p++) begin
      if (port_grant[p]) begin
        busy_d[p]  = 1'b1;
        owner_d[p] = alloc_owner[p];
        for (int unsigned r = 0; r < NR_REQ; r++) begin
          if (alloc_owner[p] == IDX_W'(r)) begin
            port_d[p] = '{addr: wport_io.req_waddr_i[r],
                          data: wport_io.req_wdata_i[r],
                          be:   wport_io.req_wbe_i[r]};
          end
        end
      end else if (retire[p]) begin
        busy_d[p] = 1'b0;
      end
    end
    outstanding_d = req_grant | (outstanding_q & ~wack);
    rr_ptr_d      = any_grant ? next_ptr : rr_ptr_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q        <= '0;
      port_q        <= '0;
      owner_q       <= '0;
      outstanding_q <= '0;
      rr_ptr_q      <= '0;
    end else begin
      busy_q        <= busy_d;
      port_q        <= port_d;
      owner_q       <= owner_d;
      outstanding_q <= outstanding_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end

  // Pending writes are dropped silently when reset hits mid-operation.
  assign wport_io.req_ready_o = rst_i ? '0 : req_grant;
  assign wport_io.req_wack_o  = rst_i ? '0 : wack;
  assign wport_io.vrf_we_o    = busy_q;

  for (genvar p = 0; p < NR_PORTS; p++) begin : g_port_out
    assign wport_io.vrf_waddr_o[p] = port_q[p].addr;
    assign wport_io.vrf_wdata_o[p] = port_q[p].data;
    assign wport_io.vrf_wbe_o[p]   = port_q[p].be;
  end

endmodule

`default_nettype wire
